// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Hardwired control sequencer for a small RISC datapath. Each instruction is
// executed as a sequence of one-cycle steps T0..T6: T0-T2 fetch the
// instruction into IR, and T3 onward run the opcode-specific micro-operations.
// The block has three phases: RESET (strobes idle, leaves after one edge),
// EXEC (fetch/execute loop) and HALT (idle until clr).
//
// Ports
//   clk                 sole clock, rising edge
//   clr                 asynchronous active-high reset
//   ir[31:0]            instruction register; opcode = ir[31:27]
//   con_ff              branch condition flag, valid from T4 of a branch
//   stop                external halt request, sampled at instruction end
//   run                 high while in EXEC
//   *_out               bus-drive strobes to the datapath
//   *_enable, r_in      register-load strobes to the datapath
//   pc_increment, read  PC+1 select into Z, memory read
//   gra, grb, grc       register-file field selects (ra / rb / rc)
//   zhi_out, hi_enable, lo_enable, inport_enable, inport_out,
//   outport_enable, ram_write   unused by this instruction subset, held 0
//
// All outputs are decoded combinationally from the registered phase/step,
// the opcode and con_ff.
// -----------------------------------------------------------------------------
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic        pc_out,
  output logic        zlo_out,
  output logic        hi_out,
  output logic        lo_out,
  output logic        mdr_out,
  output logic        ba_out,
  output logic        r_out,
  output logic        c_sign_extended_out,
  output logic        pc_enable,
  output logic        mar_enable,
  output logic        mdr_enable,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        z_enable,
  output logic        r_in,
  output logic        con_enable,
  output logic        pc_increment,
  output logic        read,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        zhi_out,
  output logic        hi_enable,
  output logic        lo_enable,
  output logic        inport_enable,
  output logic        inport_out,
  output logic        outport_enable,
  output logic        ram_write
);

  typedef enum logic [1:0] {
    PH_RESET = 2'd0,
    PH_EXEC  = 2'd1,
    PH_HALT  = 2'd2
  } phase_t;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;

  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  phase_t     phase_q, phase_d;
  logic [2:0] step_q, step_d;
  logic [4:0] opcode;
  logic [2:0] last_step;
  logic       is_halt;

  assign opcode  = ir[31:27];
  assign is_halt = (opcode == OP_HALT);

  // Final step of each instruction class; unknown opcodes behave as nop.
  always_comb begin
    last_step = T3;
    case (opcode)
      OP_LDI, OP_ADDI, OP_ADD, OP_SUB: last_step = T5;
      OP_BR:                           last_step = T6;
      default:                         last_step = T3;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    step_d  = step_q;
    case (phase_q)
      PH_RESET: begin
        phase_d = PH_EXEC;
        step_d  = T0;
      end
      PH_EXEC: begin
        if (step_q > T6) begin
          // Unreachable encoding: recover to the start of a fetch.
          step_d = T0;
        end else if (step_q >= T3 && step_q == last_step) begin
          // stop is only honoured here so an instruction is never cut short.
          step_d = T0;
          if (is_halt || stop) phase_d = PH_HALT;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      PH_HALT: begin
        phase_d = PH_HALT;
        step_d  = T0;
      end
      default: begin
        phase_d = PH_RESET;
        step_d  = T0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      phase_q <= PH_RESET;
      step_q  <= T0;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
    end
  end

  // Strobe decode. Everything idles outside EXEC.
  always_comb begin
    run                 = 1'b0;
    pc_out              = 1'b0;
    zlo_out             = 1'b0;
    hi_out              = 1'b0;
    lo_out              = 1'b0;
    mdr_out             = 1'b0;
    ba_out              = 1'b0;
    r_out               = 1'b0;
    c_sign_extended_out = 1'b0;
    pc_enable           = 1'b0;
    mar_enable          = 1'b0;
    mdr_enable          = 1'b0;
    ir_enable           = 1'b0;
    y_enable            = 1'b0;
    z_enable            = 1'b0;
    r_in                = 1'b0;
    con_enable          = 1'b0;
    pc_increment        = 1'b0;
    read                = 1'b0;
    gra                 = 1'b0;
    grb                 = 1'b0;
    grc                 = 1'b0;
    if (phase_q == PH_EXEC) begin
      run = 1'b1;
      case (step_q)
        T0: begin
          pc_out       = 1'b1;
          mar_enable   = 1'b1;
          pc_increment = 1'b1;
          z_enable     = 1'b1;
        end
        T1: begin
          zlo_out    = 1'b1;
          pc_enable  = 1'b1;
          read       = 1'b1;
          mdr_enable = 1'b1;
        end
        T2: begin
          mdr_out   = 1'b1;
          ir_enable = 1'b1;
        end
        T3: begin
          case (opcode)
            OP_LDI: begin
              grb      = 1'b1;
              ba_out   = 1'b1;
              y_enable = 1'b1;
            end
            OP_ADDI, OP_ADD, OP_SUB: begin
              grb      = 1'b1;
              r_out    = 1'b1;
              y_enable = 1'b1;
            end
            OP_MFHI: begin
              hi_out = 1'b1;
              gra    = 1'b1;
              r_in   = 1'b1;
            end
            OP_MFLO: begin
              lo_out = 1'b1;
              gra    = 1'b1;
              r_in   = 1'b1;
            end
            OP_BR: begin
              gra        = 1'b1;
              r_out      = 1'b1;
              con_enable = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          case (opcode)
            OP_LDI, OP_ADDI: begin
              c_sign_extended_out = 1'b1;
              z_enable            = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              grc      = 1'b1;
              r_out    = 1'b1;
              z_enable = 1'b1;
            end
            OP_BR: begin
              pc_out   = 1'b1;
              y_enable = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDI, OP_ADDI, OP_ADD, OP_SUB: begin
              zlo_out = 1'b1;
              gra     = 1'b1;
              r_in    = 1'b1;
            end
            OP_BR: begin
              c_sign_extended_out = 1'b1;
              z_enable            = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_BR) begin
            zlo_out   = 1'b1;
            pc_enable = con_ff;
          end
        end
        default: ;
      endcase
    end
  end

  assign zhi_out        = 1'b0;
  assign hi_enable      = 1'b0;
  assign lo_enable      = 1'b0;
  assign inport_enable  = 1'b0;
  assign inport_out     = 1'b0;
  assign outport_enable = 1'b0;
  assign ram_write      = 1'b0;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic run, pc_out, zlo_out, hi_out, lo_out, mdr_out, ba_out, r_out;
  logic c_sign_extended_out, pc_enable, mar_enable, mdr_enable, ir_enable;
  logic y_enable, z_enable, r_in, con_enable, pc_increment, read;
  logic gra, grb, grc, zhi_out, hi_enable, lo_enable, inport_enable;
  logic inport_out, outport_enable, ram_write;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .run(run), .pc_out(pc_out), .zlo_out(zlo_out), .hi_out(hi_out),
    .lo_out(lo_out), .mdr_out(mdr_out), .ba_out(ba_out), .r_out(r_out),
    .c_sign_extended_out(c_sign_extended_out), .pc_enable(pc_enable),
    .mar_enable(mar_enable), .mdr_enable(mdr_enable), .ir_enable(ir_enable),
    .y_enable(y_enable), .z_enable(z_enable), .r_in(r_in),
    .con_enable(con_enable), .pc_increment(pc_increment), .read(read),
    .gra(gra), .grb(grb), .grc(grc), .zhi_out(zhi_out),
    .hi_enable(hi_enable), .lo_enable(lo_enable),
    .inport_enable(inport_enable), .inport_out(inport_out),
    .outport_enable(outport_enable), .ram_write(ram_write)
  );

  // One bit per output, run in bit 0.
  localparam logic [28:0] RUN    = 29'd1 << 0;
  localparam logic [28:0] PC_OUT = 29'd1 << 1;
  localparam logic [28:0] ZLO    = 29'd1 << 2;
  localparam logic [28:0] HI     = 29'd1 << 3;
  localparam logic [28:0] LO     = 29'd1 << 4;
  localparam logic [28:0] MDR_O  = 29'd1 << 5;
  localparam logic [28:0] BA     = 29'd1 << 6;
  localparam logic [28:0] R_OUT  = 29'd1 << 7;
  localparam logic [28:0] CSE    = 29'd1 << 8;
  localparam logic [28:0] PC_EN  = 29'd1 << 9;
  localparam logic [28:0] MAR_EN = 29'd1 << 10;
  localparam logic [28:0] MDR_EN = 29'd1 << 11;
  localparam logic [28:0] IR_EN  = 29'd1 << 12;
  localparam logic [28:0] Y_EN   = 29'd1 << 13;
  localparam logic [28:0] Z_EN   = 29'd1 << 14;
  localparam logic [28:0] R_IN   = 29'd1 << 15;
  localparam logic [28:0] CON_EN = 29'd1 << 16;
  localparam logic [28:0] PC_INC = 29'd1 << 17;
  localparam logic [28:0] READ   = 29'd1 << 18;
  localparam logic [28:0] GRA    = 29'd1 << 19;
  localparam logic [28:0] GRB    = 29'd1 << 20;
  localparam logic [28:0] GRC    = 29'd1 << 21;

  localparam logic [28:0] E_T0 = RUN | PC_OUT | MAR_EN | PC_INC | Z_EN;
  localparam logic [28:0] E_T1 = RUN | ZLO | PC_EN | READ | MDR_EN;
  localparam logic [28:0] E_T2 = RUN | MDR_O | IR_EN;
  localparam logic [28:0] E_IDLE = 29'd0;
  localparam logic [28:0] E_LDI3 = RUN | GRB | BA | Y_EN;
  localparam logic [28:0] E_IMM4 = RUN | CSE | Z_EN;
  localparam logic [28:0] E_WB5  = RUN | ZLO | GRA | R_IN;
  localparam logic [28:0] E_RR3  = RUN | GRB | R_OUT | Y_EN;
  localparam logic [28:0] E_RR4  = RUN | GRC | R_OUT | Z_EN;
  localparam logic [28:0] E_MFHI = RUN | HI | GRA | R_IN;
  localparam logic [28:0] E_MFLO = RUN | LO | GRA | R_IN;
  localparam logic [28:0] E_BR3  = RUN | GRA | R_OUT | CON_EN;
  localparam logic [28:0] E_BR4  = RUN | PC_OUT | Y_EN;
  localparam logic [28:0] E_BR5  = RUN | CSE | Z_EN;
  localparam logic [28:0] E_NOP3 = RUN;

  logic [28:0] act;
  assign act = {ram_write, outport_enable, inport_out, inport_enable,
                lo_enable, hi_enable, zhi_out, grc, grb, gra, read,
                pc_increment, con_enable, r_in, z_enable, y_enable,
                ir_enable, mdr_enable, mar_enable, pc_enable,
                c_sign_extended_out, r_out, ba_out, mdr_out, lo_out,
                hi_out, zlo_out, pc_out, run};

  logic [28:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  // Monitor: every cycle the DUT presents a strobe vector; compare it
  // against the oldest expectation the driver queued.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      logic [28:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL strobes cyc%0d: got %h required %h", cyc, act, e);
    end
  end

  task automatic step(input logic [28:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    step(E_T0);
    step(E_T1);
    step(E_T2);
  endtask

  task automatic set_op(input logic [4:0] op);
    ir = {op, 27'h0155AA5};
  endtask

  task automatic recover();
    clr = 1'b1;
    step(E_IDLE);
    clr = 1'b0;
    step(E_IDLE);
  endtask

  initial begin
    clr = 1'b1; ir = 32'h0; con_ff = 1'b0; stop = 1'b0;
    @(posedge clk);
    #1;
    step(E_IDLE);
    step(E_IDLE);
    clr = 1'b0;
    step(E_IDLE);             // RESET cycle after release

    // ldi
    ir = 32'h0880001B;
    fetch(); step(E_LDI3); step(E_IMM4); step(E_WB5);
    // addi
    set_op(5'b01100);
    fetch(); step(E_RR3); step(E_IMM4); step(E_WB5);
    // add, sub
    set_op(5'b00011);
    fetch(); step(E_RR3); step(E_RR4); step(E_WB5);
    set_op(5'b00100);
    fetch(); step(E_RR3); step(E_RR4); step(E_WB5);
    // mfhi, mflo, nop, undefined opcode
    set_op(5'b10111); fetch(); step(E_MFHI);
    set_op(5'b11000); fetch(); step(E_MFLO);
    set_op(5'b11001); fetch(); step(E_NOP3);
    set_op(5'b11111); fetch(); step(E_NOP3);
    // br taken / not taken
    set_op(5'b10010); con_ff = 1'b1;
    fetch(); step(E_BR3); step(E_BR4); step(E_BR5); step(RUN | ZLO | PC_EN);
    con_ff = 1'b0;
    fetch(); step(E_BR3); step(E_BR4); step(E_BR5); step(RUN | ZLO);
    // clr pulse mid-T4 of add
    set_op(5'b00011);
    fetch(); step(E_RR3);
    recover();
    fetch(); step(E_RR3); step(E_RR4); step(E_WB5);
    // halt opcode
    set_op(5'b11010);
    fetch(); step(E_NOP3);
    for (int i = 0; i < 4; i++) step(E_IDLE);
    recover();
    // stop raised in T1 of add: instruction completes, then HALT
    set_op(5'b00011);
    step(E_T0);
    stop = 1'b1;
    step(E_T1); step(E_T2); step(E_RR3); step(E_RR4); step(E_WB5);
    stop = 1'b0;
    for (int i = 0; i < 11; i++) step(E_IDLE);
    // clr during HALT, then normal restart
    recover();
    set_op(5'b11001);
    fetch(); step(E_NOP3);
    step(E_T0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and one reset: clk is the only clock, and clr is an asynchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 clr  in  1  asynchronous active-high reset.
REQ-004 ir  in  32  instruction register contents from Datapath; opcode = ir[31:27].
REQ-005 con_ff  in  1  branch condition flag from Datapath, valid from T4 of a branch.
REQ-006 stop  in  1  external halt request.
REQ-007 run  out  1  high while executing, low in RESET and HALT.
REQ-008 pc_out, zlo_out, hi_out, lo_out, mdr_out, ba_out, r_out, c_sign_extended_out  out  1 each  bus-drive strobes to Datapath.
REQ-009 pc_enable, mar_enable, mdr_enable, ir_enable, y_enable, z_enable, r_in, con_enable  out  1 each  register-load strobes to Datapath.
REQ-010 pc_increment, read  out  1 each  PC+1 select into Z, and memory read.
REQ-011 gra, grb, grc  out  1 each  select the ra/rb/rc field of ir for the register file.
REQ-012 zhi_out, hi_enable, lo_enable, inport_enable, inport_out, outport_enable, ram_write  out  1 each  tied 0 in this instruction subset.

Function
REQ-013 State SHALL be {phase: RESET/EXEC/HALT, step: 3-bit T0..T6}, where each step lasts exactly one clk cycle.
REQ-014 Outputs SHALL be a combinational function of registered state, ir[31:27] and con_ff only.
REQ-015 Outputs not listed for a step SHALL be 0.
REQ-016 RESET SHALL drive all strobes 0, and the next edge SHALL enter EXEC T0.
REQ-017 T0 SHALL assert pc_out, mar_enable, pc_increment and z_enable.
REQ-018 T1 SHALL assert zlo_out, pc_enable, read and mdr_enable.
REQ-019 T2 SHALL assert mdr_out and ir_enable, and step SHALL always advance to T3, with ir valid from T3 onward.
REQ-020 Opcode map SHALL be: ldi 00001, add 00011, sub 00100, addi 01100, br 10010, mfhi 10111, mflo 11000, nop 11001, halt 11010; every other opcode SHALL execute as nop.
REQ-021 ldi SHALL assert: T3 grb, ba_out, y_enable; T4 c_sign_extended_out, z_enable; T5 zlo_out, gra, r_in.
REQ-022 addi SHALL execute as ldi, except that T3 uses r_out instead of ba_out.
REQ-023 add/sub SHALL assert: T3 grb, r_out, y_enable; T4 grc, r_out, z_enable; T5 zlo_out, gra, r_in; the ALU function is decoded by the Datapath from ir.
REQ-024 mfhi SHALL assert in T3: hi_out, gra, r_in; mflo SHALL assert lo_out in place of hi_out.
REQ-025 br SHALL assert: T3 gra, r_out, con_enable; T4 pc_out, y_enable; T5 c_sign_extended_out, z_enable; T6 zlo_out, with pc_enable = con_ff.
REQ-026 nop SHALL assert no strobes in T3.
REQ-027 The last step SHALL be: T3 for mfhi/mflo/nop/halt, T5 for ldi/addi/add/sub, and T6 for br.
REQ-028 At the edge ending the last step, step SHALL return to T0 unless halt or stop applies.
REQ-029 When halt is decoded, the edge ending T3 SHALL enter HALT.
REQ-030 stop SHALL be sampled only at the edge ending a last step; if 1, the block SHALL enter HALT instead of T0.
REQ-031 stop asserted mid-instruction SHALL NOT truncate the instruction.
REQ-032 HALT SHALL hold all strobes 0 and run=0 until clr, with no other exit.
REQ-033 step SHALL never exceed T6; an unreachable step value SHALL return to T0 on the next edge.

Reset
REQ-034 While clr=1, asynchronously: phase=RESET, step=T0, run=0, all strobes 0.
REQ-035 A clr assertion mid-instruction, including during HALT, SHALL abort immediately with no further strobes.
REQ-036 After clr falls, the first rising edge SHALL give RESET->T0, so the first fetch strobes appear one cycle after release.

Verification
REQ-037 Scenario: pulse clr mid-T4 of add -> all outputs 0 immediately, run=0; after release, one RESET cycle, then T0 strobes (pc_out=mar_enable=pc_increment=z_enable=1).
REQ-038 Scenario: ir=0x0880001B (ldi) -> cycles 3/4/5 after T0 show the exact ldi strobe sets, and the next cycle is T0 again (6-cycle instruction).
REQ-039 Scenario: ir opcode 10111 (mfhi) -> T3 hi_out=gra=r_in=1, with all other strobes 0, then T0; the same with mflo shows lo_out.
REQ-040 Scenario: br with con_ff=1 -> T6 zlo_out=1, pc_enable=1; br with con_ff=0 -> T6 zlo_out=1, pc_enable=0; the next cycle is T0 in both cases.
REQ-041 Scenario: stop raised in T1 of add -> add completes through T5, then HALT with run=0 and all strobes 0 for at least 10 cycles.
REQ-042 Scenario: opcode 11010 (halt) -> HALT after T3; opcode 11111 -> nop behaviour, returning to T0 after T3.
